// File: rtl/gpu_pkg.sv
// Shared GPU definitions: core pipeline state encodings seen by the LSU and the
// LSU state enum that is exported on lsu_state.
package gpu_pkg;

  // Core pipeline states the LSU reacts to.
  localparam logic [2:0] CoreRequest = 3'b011;
  localparam logic [2:0] CoreUpdate  = 3'b110;

  typedef enum logic [2:0] {
    LsuIdle       = 3'd0,
    LsuRequesting = 3'd1,
    LsuWaiting    = 3'd2,
    LsuDone       = 3'd3,
    LsuError      = 3'd4
  } lsu_state_e;

endpackage

// File: rtl/lsu_gen2.sv
// Per-thread load/store unit.
// Latches one LDR/STR when the core is in REQUEST, issues a single memory read or
// write handshake, waits for the matching ready (with an optional timeout), then
// parks in DONE/ERROR until the core reaches UPDATE.
//
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   enable                     thread active; 0 freezes all state
//   core_state                 core pipeline state
//   decoded_mem_read_enable    LDR decoded
//   decoded_mem_write_enable   STR decoded
//   rs, rt, imm                base address, store data, signed 4-bit offset
//   mem_read_*                 read request channel (valid/address out, ready/data in)
//   mem_write_*                write request channel (valid/address/data out, ready in)
//   lsu_state                  current LSU state (gpu_pkg::lsu_state_e encoding)
//   lsu_out                    last load result
//   lsu_error                  error flag for the current instruction
module lsu_gen2
  import gpu_pkg::*;
#(
  parameter int unsigned ADDR_BITS      = 8,
  parameter int unsigned DATA_BITS      = 8,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 enable,
  input  logic [2:0]           core_state,
  input  logic                 decoded_mem_read_enable,
  input  logic                 decoded_mem_write_enable,
  input  logic [DATA_BITS-1:0] rs,
  input  logic [DATA_BITS-1:0] rt,
  input  logic [3:0]           imm,
  output logic                 mem_read_valid,
  output logic [ADDR_BITS-1:0] mem_read_address,
  input  logic                 mem_read_ready,
  input  logic [DATA_BITS-1:0] mem_read_data,
  output logic                 mem_write_valid,
  output logic [ADDR_BITS-1:0] mem_write_address,
  output logic [DATA_BITS-1:0] mem_write_data,
  input  logic                 mem_write_ready,
  output logic [2:0]           lsu_state,
  output logic [DATA_BITS-1:0] lsu_out,
  output logic                 lsu_error
);

  // A zero timeout still needs a legal (1-bit) counter.
  localparam int unsigned CntW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CntW-1:0] TimeoutCnt = CntW'(TIMEOUT_CYCLES);

  lsu_state_e           state_q, state_d;
  logic                 is_wr_q, is_wr_d;
  logic [ADDR_BITS-1:0] addr_q, addr_d;
  logic [DATA_BITS-1:0] wdata_q, wdata_d;
  logic                 rvalid_q, rvalid_d;
  logic                 wvalid_q, wvalid_d;
  logic [ADDR_BITS-1:0] raddr_q, raddr_d;
  logic [ADDR_BITS-1:0] waddr_q, waddr_d;
  logic [DATA_BITS-1:0] mwdata_q, mwdata_d;
  logic [DATA_BITS-1:0] out_q, out_d;
  logic                 err_q, err_d;
  logic [CntW-1:0]      cnt_q, cnt_d;

  logic [ADDR_BITS-1:0] imm_ext;
  logic                 ready_hit;

  // Size cast of a signed value sign-extends the offset to the address width.
  assign imm_ext   = ADDR_BITS'($signed(imm));
  // Only the ready of the channel actually in use counts.
  assign ready_hit = is_wr_q ? mem_write_ready : mem_read_ready;

  always_comb begin
    state_d  = state_q;
    is_wr_d  = is_wr_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    rvalid_d = rvalid_q;
    wvalid_d = wvalid_q;
    raddr_d  = raddr_q;
    waddr_d  = waddr_q;
    mwdata_d = mwdata_q;
    out_d    = out_q;
    err_d    = err_q;
    cnt_d    = cnt_q;

    unique case (state_q)
      LsuIdle: begin
        if (core_state == CoreRequest) begin
          if (decoded_mem_read_enable && decoded_mem_write_enable) begin
            // Conflicting decode: refuse to touch memory.
            state_d = LsuError;
            err_d   = 1'b1;
          end else if (decoded_mem_read_enable || decoded_mem_write_enable) begin
            state_d = LsuRequesting;
            is_wr_d = decoded_mem_write_enable;
            addr_d  = rs[ADDR_BITS-1:0] + imm_ext;
            wdata_d = rt;
            cnt_d   = '0;
          end
        end
      end

      LsuRequesting: begin
        if (is_wr_q) begin
          wvalid_d = 1'b1;
          waddr_d  = addr_q;
          mwdata_d = wdata_q;
        end else begin
          rvalid_d = 1'b1;
          raddr_d  = addr_q;
        end
        state_d = LsuWaiting;
      end

      LsuWaiting: begin
        if (ready_hit) begin
          rvalid_d = 1'b0;
          wvalid_d = 1'b0;
          if (!is_wr_q) out_d = mem_read_data;
          cnt_d   = '0;
          state_d = LsuDone;
        end else begin
          cnt_d = cnt_q + 1'b1;
          if ((TIMEOUT_CYCLES != 0) && (cnt_d == TimeoutCnt)) begin
            rvalid_d = 1'b0;
            wvalid_d = 1'b0;
            err_d    = 1'b1;
            cnt_d    = '0;
            state_d  = LsuError;
          end
        end
      end

      LsuDone, LsuError: begin
        if (core_state == CoreUpdate) begin
          state_d = LsuIdle;
          err_d   = 1'b0;
        end
      end

      default: state_d = LsuIdle;
    endcase
  end

  // Reset has priority; enable low holds every register, including the counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= LsuIdle;
      is_wr_q  <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rvalid_q <= 1'b0;
      wvalid_q <= 1'b0;
      raddr_q  <= '0;
      waddr_q  <= '0;
      mwdata_q <= '0;
      out_q    <= '0;
      err_q    <= 1'b0;
      cnt_q    <= '0;
    end else if (enable) begin
      state_q  <= state_d;
      is_wr_q  <= is_wr_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      rvalid_q <= rvalid_d;
      wvalid_q <= wvalid_d;
      raddr_q  <= raddr_d;
      waddr_q  <= waddr_d;
      mwdata_q <= mwdata_d;
      out_q    <= out_d;
      err_q    <= err_d;
      cnt_q    <= cnt_d;
    end
  end

  assign mem_read_valid    = rvalid_q;
  assign mem_read_address  = raddr_q;
  assign mem_write_valid   = wvalid_q;
  assign mem_write_address = waddr_q;
  assign mem_write_data    = mwdata_q;
  assign lsu_state         = state_q;
  assign lsu_out           = out_q;
  assign lsu_error         = err_q;

endmodule

// File: tb/tb_lsu_gen2.sv
// Scoreboard bench for lsu_gen2: stimulus pushes expected memory requests and
// final results into queues, a negedge monitor pops and compares them.
module tb_lsu_gen2;

  localparam int TO = 4;
  localparam logic [2:0] CS_REQ = 3'b011;
  localparam logic [2:0] CS_UPD = 3'b110;

  logic       clk, reset, enable;
  logic [2:0] core_state;
  logic       dec_rd, dec_wr;
  logic [7:0] rs, rt;
  logic [3:0] imm;
  logic       mem_read_valid, mem_read_ready;
  logic [7:0] mem_read_address, mem_read_data;
  logic       mem_write_valid, mem_write_ready;
  logic [7:0] mem_write_address, mem_write_data;
  logic [2:0] lsu_state;
  logic [7:0] lsu_out;
  logic       lsu_error;

  lsu_gen2 #(
    .ADDR_BITS     (8),
    .DATA_BITS     (8),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk                     (clk),
    .reset                   (reset),
    .enable                  (enable),
    .core_state              (core_state),
    .decoded_mem_read_enable (dec_rd),
    .decoded_mem_write_enable(dec_wr),
    .rs                      (rs),
    .rt                      (rt),
    .imm                     (imm),
    .mem_read_valid          (mem_read_valid),
    .mem_read_address        (mem_read_address),
    .mem_read_ready          (mem_read_ready),
    .mem_read_data           (mem_read_data),
    .mem_write_valid         (mem_write_valid),
    .mem_write_address       (mem_write_address),
    .mem_write_data          (mem_write_data),
    .mem_write_ready         (mem_write_ready),
    .lsu_state               (lsu_state),
    .lsu_out                 (lsu_out),
    .lsu_error               (lsu_error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit         is_wr;
    logic [7:0] addr;
    logic [7:0] data;
    int         len;
  } req_t;

  typedef struct {
    int         st;
    logic [7:0] out;
    bit         err;
  } res_t;

  req_t req_q[$];
  res_t res_q[$];

  int total = 0;
  int bad   = 0;
  bit mon_en = 1'b0;
  logic [7:0] exp_out = 8'h00;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [2:0] rand_cs();
    logic [2:0] v;
    v = 3'($urandom_range(0, 7));
    if (v == CS_REQ || v == CS_UPD) v = 3'b000;
    return v;
  endfunction

  // Monitor
  logic prv_r = 1'b0, prv_w = 1'b0;
  int   prv_st = 0;
  bit   has_cur = 1'b0;
  int   vcnt = 0;
  req_t cur;

  always @(negedge clk) begin
    if (mon_en) begin
      res_t s;
      if (mem_read_valid || mem_write_valid) begin
        chk("one_valid_only", 32'(mem_read_valid & mem_write_valid), 32'd0);
        if (!(prv_r || prv_w)) begin
          if (req_q.size() == 0) begin
            chk("unexpected_request", 32'd1, 32'd0);
            has_cur = 1'b0;
          end else begin
            cur = req_q.pop_front();
            has_cur = 1'b1;
            vcnt = 0;
          end
        end
        if (has_cur) begin
          vcnt++;
          if (cur.is_wr) begin
            chk("wr_valid", 32'(mem_write_valid), 32'd1);
            chk("wr_addr", 32'(mem_write_address), 32'(cur.addr));
            chk("wr_data", 32'(mem_write_data), 32'(cur.data));
          end else begin
            chk("rd_valid", 32'(mem_read_valid), 32'd1);
            chk("rd_addr", 32'(mem_read_address), 32'(cur.addr));
          end
        end
      end else if ((prv_r || prv_w) && has_cur) begin
        chk("valid_len", 32'(vcnt), 32'(cur.len));
        has_cur = 1'b0;
      end
      if ((lsu_state == 3'd3 || lsu_state == 3'd4) && int'(lsu_state) != prv_st) begin
        if (res_q.size() == 0) begin
          chk("unexpected_result", 32'd1, 32'd0);
        end else begin
          s = res_q.pop_front();
          chk("end_state", 32'(lsu_state), 32'(s.st));
          chk("lsu_out", 32'(lsu_out), 32'(s.out));
          chk("lsu_error", 32'(lsu_error), 32'(s.err));
        end
      end
      if (lsu_state == 3'd0 && (prv_st == 3 || prv_st == 4))
        chk("error_cleared", 32'(lsu_error), 32'd0);
      prv_r  = mem_read_valid;
      prv_w  = mem_write_valid;
      prv_st = int'(lsu_state);
    end
  end

  // op: 0 load, 1 store, 2 conflicting decode. k: WAITING cycle carrying ready.
  task automatic do_txn(input int op, input logic [7:0] rs_v, input logic [7:0] rt_v,
                        input logic [3:0] imm_v, input int k, input logic [7:0] rdata);
    req_t r;
    res_t s;
    bit   hit;
    r.addr = rs_v + {{4{imm_v[3]}}, imm_v};
    s.err  = 1'b0;
    s.st   = 3;
    if (op == 2) begin
      s.st  = 4;
      s.err = 1'b1;
    end else begin
      r.is_wr = (op == 1);
      r.data  = rt_v;
      r.len   = (k <= TO) ? k : TO;
      req_q.push_back(r);
      if (k <= TO) begin
        if (op == 0) exp_out = rdata;
      end else begin
        s.st  = 4;
        s.err = 1'b1;
      end
    end
    s.out = exp_out;
    res_q.push_back(s);

    core_state = CS_REQ;
    dec_rd = (op != 1);
    dec_wr = (op != 0);
    rs = rs_v; rt = rt_v; imm = imm_v;
    for (int c = 1; c <= 7; c++) begin
      @(posedge clk); #1;
      core_state = rand_cs();
      dec_rd = 1'($urandom); dec_wr = 1'($urandom);
      rs = 8'($urandom); rt = 8'($urandom); imm = 4'($urandom);
      mem_read_data = 8'($urandom);
      mem_read_ready = 1'b0; mem_write_ready = 1'b0;
      if (c >= 2) begin
        hit = ((c - 1) == k);
        if (op == 0) begin
          mem_read_ready  = hit;
          mem_write_ready = 1'($urandom);
          if (hit) mem_read_data = rdata;
        end else if (op == 1) begin
          mem_write_ready = hit;
          mem_read_ready  = 1'($urandom);
        end else begin
          mem_read_ready  = 1'($urandom);
          mem_write_ready = 1'($urandom);
        end
      end
    end
    @(posedge clk); #1;
    mem_read_ready = 1'b0; mem_write_ready = 1'b0;
    core_state = rand_cs();
    repeat ($urandom_range(0, 2)) begin
      @(posedge clk); #1;
    end
    core_state = CS_UPD;
    @(posedge clk); #1;
    core_state = rand_cs();
    @(negedge clk);
    chk("idle_after_update", 32'(lsu_state), 32'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, total=%0d", total);
    $fatal(1, "watchdog");
  end

  initial begin
    int op;
    reset = 1'b1; enable = 1'b1; core_state = 3'b000;
    dec_rd = 1'b0; dec_wr = 1'b0; rs = 8'h00; rt = 8'h00; imm = 4'h0;
    mem_read_ready = 1'b0; mem_read_data = 8'h00; mem_write_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    chk("rst_state", 32'(lsu_state), 32'd0);
    chk("rst_out", 32'(lsu_out), 32'd0);
    chk("rst_err", 32'(lsu_error), 32'd0);
    chk("rst_rvalid", 32'(mem_read_valid), 32'd0);
    chk("rst_wvalid", 32'(mem_write_valid), 32'd0);
    chk("rst_raddr", 32'(mem_read_address), 32'd0);
    chk("rst_waddr", 32'(mem_write_address), 32'd0);
    chk("rst_wdata", 32'(mem_write_data), 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    mon_en = 1'b1;

    // Directed: load, wrapping store, timeout, conflict.
    do_txn(0, 8'h10, 8'h00, 4'h2, 3, 8'hA5);
    do_txn(1, 8'hFF, 8'h3C, 4'h1, 1, 8'h00);
    do_txn(0, 8'h05, 8'h00, 4'h8, 6, 8'h11);
    do_txn(2, 8'h40, 8'h99, 4'h0, 1, 8'h00);

    for (int t = 0; t < 40; t++) begin
      op = $urandom_range(0, 9);
      op = (op < 5) ? 0 : (op < 9) ? 1 : 2;
      do_txn(op, 8'($urandom), 8'($urandom), 4'($urandom), $urandom_range(1, 6),
             8'($urandom));
    end

    @(negedge clk);
    chk("req_q_drained", 32'(req_q.size()), 32'd0);
    chk("res_q_drained", 32'(res_q.size()), 32'd0);
    mon_en = 1'b0;

    // Freeze mid-WAITING: counter must resume where it stopped.
    @(posedge clk); #1;
    core_state = CS_REQ; dec_rd = 1'b1; dec_wr = 1'b0; rs = 8'h20; imm = 4'hF;
    @(posedge clk); #1;
    core_state = 3'b000; dec_rd = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    chk("frz_w1_valid", 32'(mem_read_valid), 32'd1);
    chk("frz_w1_addr", 32'(mem_read_address), 32'h1F);
    @(posedge clk); #1;
    enable = 1'b0;
    for (int i = 0; i < 5; i++) begin
      mem_read_ready = (i == 2);
      mem_read_data = 8'hEE;
      @(negedge clk);
      chk("frz_valid", 32'(mem_read_valid), 32'd1);
      chk("frz_addr", 32'(mem_read_address), 32'h1F);
      chk("frz_state", 32'(lsu_state), 32'd2);
      chk("frz_out", 32'(lsu_out), 32'(exp_out));
      @(posedge clk); #1;
    end
    mem_read_ready = 1'b0;
    enable = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("frz_resume_valid", 32'(mem_read_valid), 32'd1);
      @(posedge clk); #1;
    end
    @(negedge clk);
    chk("frz_to_valid", 32'(mem_read_valid), 32'd0);
    chk("frz_to_state", 32'(lsu_state), 32'd4);
    chk("frz_to_err", 32'(lsu_error), 32'd1);
    chk("frz_to_out", 32'(lsu_out), 32'(exp_out));
    @(posedge clk); #1;
    core_state = CS_UPD;
    @(posedge clk); #1;
    core_state = 3'b000;
    @(negedge clk);
    chk("frz_upd_state", 32'(lsu_state), 32'd0);
    chk("frz_upd_err", 32'(lsu_error), 32'd0);

    // Reset during a frozen WAITING; a late ready must be ignored.
    @(posedge clk); #1;
    core_state = CS_REQ; dec_rd = 1'b1; rs = 8'h40; imm = 4'h3;
    @(posedge clk); #1;
    core_state = 3'b000; dec_rd = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    enable = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    @(negedge clk);
    chk("pre_rst_valid", 32'(mem_read_valid), 32'd1);
    chk("pre_rst_addr", 32'(mem_read_address), 32'h43);
    @(posedge clk); #1;
    reset = 1'b0; enable = 1'b1;
    mem_read_ready = 1'b1; mem_read_data = 8'h77;
    exp_out = 8'h00;
    @(negedge clk);
    chk("rst2_valid", 32'(mem_read_valid), 32'd0);
    chk("rst2_state", 32'(lsu_state), 32'd0);
    chk("rst2_err", 32'(lsu_error), 32'd0);
    chk("rst2_out", 32'(lsu_out), 32'(exp_out));
    chk("rst2_raddr", 32'(mem_read_address), 32'd0);
    @(posedge clk); #1;
    mem_read_ready = 1'b0;
    @(negedge clk);
    chk("late_ready_valid", 32'(mem_read_valid), 32'd0);
    chk("late_ready_state", 32'(lsu_state), 32'd0);
    chk("late_ready_out", 32'(lsu_out), 32'(exp_out));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
